// File: rtl/spi_bus_monitor_pkg.sv
// Shared opcodes, FSM encodings and frame geometry for the SPI bus monitor.
package spi_monitor_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_SET   = 8'h02;
    localparam logic [7:0] OP_CLEAR = 8'h03;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CMD     = 2'd1;
    localparam state_t ST_PAYLOAD = 2'd2;
    localparam state_t ST_DRAIN   = 2'd3;

    // Snapshot rounded up to whole bytes, plus one trailing sequence byte.
    function automatic int resp_width(input int a, input int d, input int o);
        return ((a + d + o + 7) / 8) * 8 + 8;
    endfunction

endpackage

// File: rtl/spi_bus_monitor_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with level and edge outputs.
module spi_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    // Stage 2 is the synchronised level; stage 3 only exists for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~sync_q[2];
    assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_bus_monitor.sv
// SPI slave that streams a frame-start snapshot of the CPU buses and accepts
// a command/payload pair that edits the INPUT_SIGNAL control bits.
module spi_bus_monitor
    import spi_monitor_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    OSIG_WIDTH = 4,
    parameter int                    ISIG_WIDTH = 4,
    parameter logic [ISIG_WIDTH-1:0] ISIG_INIT  = '0
) (
    input  logic                  MCLK_IN,
    input  logic                  RESET_N_IN,
    input  logic                  SPICLK_IN,
    input  logic                  SPISI_IN,
    input  logic                  SPISS_IN,
    input  logic [ADDR_WIDTH-1:0] ADDR_IN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic [OSIG_WIDTH-1:0] OUTPUT_SIGNAL_IN,
    output logic [ISIG_WIDTH-1:0] INPUT_SIGNAL,
    output logic                  SPISO,
    output logic                  SPISO_OE,
    output logic                  FRAME_DONE
);

    localparam int RESP_W = resp_width(ADDR_WIDTH, DATA_WIDTH, OSIG_WIDTH);
    localparam int SNAP_W = RESP_W - 8;
    localparam int RAW_W  = ADDR_WIDTH + DATA_WIDTH + OSIG_WIDTH;
    localparam int CNT_W  = $clog2(RESP_W + 1);

    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(RESP_W);
    localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_PAY_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0] CNT_ONE_BYTE = CNT_W'(8);

    logic sclkLevel, sclkRise, sclkFall;
    logic siLevel, siRise, siFall;
    logic ssLevel, ssRise, ssFall;

    spi_sync_edge u_sync_sclk (
        .clk_i  (MCLK_IN),
        .rst_ni (RESET_N_IN),
        .async_i(SPICLK_IN),
        .level_o(sclkLevel),
        .rise_o (sclkRise),
        .fall_o (sclkFall)
    );

    spi_sync_edge u_sync_si (
        .clk_i  (MCLK_IN),
        .rst_ni (RESET_N_IN),
        .async_i(SPISI_IN),
        .level_o(siLevel),
        .rise_o (siRise),
        .fall_o (siFall)
    );

    spi_sync_edge u_sync_ss (
        .clk_i  (MCLK_IN),
        .rst_ni (RESET_N_IN),
        .async_i(SPISS_IN),
        .level_o(ssLevel),
        .rise_o (ssRise),
        .fall_o (ssFall)
    );

    state_t                  state_q, state_d;
    logic [RESP_W-1:0]       tx_q, tx_d;
    logic [7:0]              rx_q, rx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              cmd_q, cmd_d;
    logic [7:0]              seq_q, seq_d;
    logic                    oe_q, oe_d;
    logic                    done_q, done_d;
    logic                    pend_q, pend_d;
    logic [ISIG_WIDTH-1:0]   payload_q, payload_d;
    logic [ISIG_WIDTH-1:0]   isig_q, isig_d;

    logic [RAW_W-1:0]        snapRaw;
    logic [RESP_W-1:0]       respWord;
    logic [7:0]              rxByte;

    assign snapRaw  = {OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN};
    assign respWord = {seq_q, SNAP_W'(snapRaw)};
    assign rxByte   = {siLevel, rx_q[7:1]};

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        seq_d     = seq_q;
        oe_d      = oe_q;
        done_d    = 1'b0;
        pend_d    = 1'b0;
        payload_d = payload_q;
        isig_d    = isig_q;

        // The payload captured on the previous cycle lands here, one MCLK after the 16th rise.
        if (pend_q) begin
            case (cmd_q)
                OP_WRITE: isig_d = payload_q;
                OP_SET:   isig_d = isig_q | payload_q;
                OP_CLEAR: isig_d = isig_q & ~payload_q;
                default:  isig_d = isig_q;
            endcase
        end

        if (state_q == ST_IDLE) begin
            if (ssFall) begin
                state_d = ST_CMD;
                tx_d    = respWord;
                oe_d    = 1'b1;
                cnt_d   = '0;
                rx_d    = '0;
            end
        end else if (ssRise) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            tx_d    = '0;
            if (cnt_q >= CNT_ONE_BYTE) begin
                done_d = 1'b1;
                seq_d  = seq_q + 8'd1;
            end
        end else begin
            if (sclkRise) begin
                rx_d = rxByte;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (state_q == ST_CMD && cnt_q == CNT_CMD_LAST) begin
                    cmd_d = rxByte;
                    if (rxByte == OP_WRITE || rxByte == OP_SET || rxByte == OP_CLEAR) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                if (state_q == ST_PAYLOAD && cnt_q == CNT_PAY_LAST) begin
                    payload_d = rxByte[ISIG_WIDTH-1:0];
                    pend_d    = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            // Zero fill means SPISO settles at 0 once the whole response is out.
            if (sclkFall) begin
                tx_d = tx_q >> 1;
            end
        end
    end

    always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            cmd_q     <= OP_NOP;
            seq_q     <= '0;
            oe_q      <= 1'b0;
            done_q    <= 1'b0;
            pend_q    <= 1'b0;
            payload_q <= '0;
            isig_q    <= ISIG_INIT;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            seq_q     <= seq_d;
            oe_q      <= oe_d;
            done_q    <= done_d;
            pend_q    <= pend_d;
            payload_q <= payload_d;
            isig_q    <= isig_d;
        end
    end

    assign INPUT_SIGNAL = isig_q;
    assign SPISO        = tx_q[0];
    assign SPISO_OE     = oe_q;
    assign FRAME_DONE   = done_q;

    logic unused_sync;
    assign unused_sync = &{1'b0, sclkLevel, siRise, siFall, ssLevel, rx_q[0]};

endmodule

// File: tb/tb_spi_bus_monitor.sv
// Directed bench for spi_bus_monitor: a frame-level model tracks the expected
// control bits, sequence number and frame pulses, checked every MCLK cycle.
module tb_spi_bus_monitor;

    localparam int RESP_W = 56;

    logic        MCLK_IN = 1'b0;
    logic        RESET_N_IN;
    logic        SPICLK_IN;
    logic        SPISI_IN;
    logic        SPISS_IN;
    logic [23:0] ADDR_IN;
    logic [15:0] DATA_IN;
    logic [3:0]  OUTPUT_SIGNAL_IN;
    logic [3:0]  INPUT_SIGNAL;
    logic        SPISO;
    logic        SPISO_OE;
    logic        FRAME_DONE;

    int checks   = 0;
    int failures = 0;

    logic [3:0] modelIsig = 4'hA;
    logic [7:0] modelSeq  = 8'h00;
    logic       modelOe   = 1'b0;
    logic       modelDone = 1'b0;
    bit         checkEn   = 1'b0;

    logic [RESP_W-1:0] got;

    spi_bus_monitor #(
        .ADDR_WIDTH(24),
        .DATA_WIDTH(16),
        .OSIG_WIDTH(4),
        .ISIG_WIDTH(4),
        .ISIG_INIT (4'hA)
    ) dut (
        .MCLK_IN         (MCLK_IN),
        .RESET_N_IN      (RESET_N_IN),
        .SPICLK_IN       (SPICLK_IN),
        .SPISI_IN        (SPISI_IN),
        .SPISS_IN        (SPISS_IN),
        .ADDR_IN         (ADDR_IN),
        .DATA_IN         (DATA_IN),
        .OUTPUT_SIGNAL_IN(OUTPUT_SIGNAL_IN),
        .INPUT_SIGNAL    (INPUT_SIGNAL),
        .SPISO           (SPISO),
        .SPISO_OE        (SPISO_OE),
        .FRAME_DONE      (FRAME_DONE)
    );

    always #5 MCLK_IN = ~MCLK_IN;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling MCLK edge.
    always @(negedge MCLK_IN) begin
        if (checkEn) begin
            checkOutput("INPUT_SIGNAL", 64'(INPUT_SIGNAL), 64'(modelIsig));
            checkOutput("SPISO_OE", 64'(SPISO_OE), 64'(modelOe));
            checkOutput("FRAME_DONE", 64'(FRAME_DONE), 64'(modelDone));
            if (!modelOe) begin
                checkOutput("SPISO idle", 64'(SPISO), 64'd0);
            end
        end
    end

    // Entered on a falling MCLK edge; a pin change takes effect 3 rising edges later.
    task automatic driveSs(input logic level, input int bitsSeen);
        SPISS_IN = level;
        repeat (3) @(posedge MCLK_IN);
        if (level) begin
            if (modelOe) begin
                modelOe = 1'b0;
                if (bitsSeen >= 8) begin
                    modelDone = 1'b1;
                    modelSeq  = modelSeq + 8'd1;
                end
            end
        end else begin
            modelOe = 1'b1;
        end
        @(posedge MCLK_IN);
        modelDone = 1'b0;
        repeat (2) @(negedge MCLK_IN);
    endtask

    task automatic sclkHalf(input logic level, input logic si, input bit upd, input logic [3:0] newIsig);
        SPISI_IN  = si;
        SPICLK_IN = level;
        repeat (4) @(posedge MCLK_IN);
        if (upd) modelIsig = newIsig;
        repeat (2) @(negedge MCLK_IN);
    endtask

    task automatic applyStimulus(input int nBits, input logic [15:0] mosi, input int addrChangeAt,
                                 output logic [RESP_W-1:0] rxWord);
        logic [RESP_W-1:0] expWord;
        logic [RESP_W-1:0] mask;
        logic [7:0]        op;
        logic [3:0]        pay;
        logic [3:0]        nextIsig;
        logic              siBit;
        expWord = {modelSeq, 4'h0, OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN};
        op      = mosi[7:0];
        pay     = mosi[11:8];
        rxWord  = '0;
        SPISI_IN = mosi[0];
        driveSs(1'b0, 0);
        for (int i = 0; i < nBits; i++) begin
            rxWord[i] = SPISO;
            case (op)
                8'h01:   nextIsig = pay;
                8'h02:   nextIsig = modelIsig | pay;
                8'h03:   nextIsig = modelIsig & ~pay;
                default: nextIsig = modelIsig;
            endcase
            siBit = (i < 16) ? mosi[i] : 1'b0;
            sclkHalf(1'b1, siBit, (i == 15) && (op >= 8'h01) && (op <= 8'h03), nextIsig);
            sclkHalf(1'b0, siBit, 1'b0, 4'h0);
            if (i + 1 == addrChangeAt) ADDR_IN = 24'hFFFFFF;
        end
        mask = (nBits >= RESP_W) ? '1 : ((RESP_W'(1) << nBits) - RESP_W'(1));
        checkOutput("MISO word", 64'(rxWord & mask), 64'(expWord & mask));
        driveSs(1'b1, nBits);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RESET_N_IN       = 1'b0;
        SPISS_IN         = 1'b1;
        SPICLK_IN        = 1'b0;
        SPISI_IN         = 1'b0;
        ADDR_IN          = 24'h123456;
        DATA_IN          = 16'hBEEF;
        OUTPUT_SIGNAL_IN = 4'h5;
        repeat (3) @(negedge MCLK_IN);
        checkOutput("reset INPUT_SIGNAL", 64'(INPUT_SIGNAL), 64'h A);
        checkOutput("reset SPISO_OE", 64'(SPISO_OE), 64'd0);
        checkOutput("reset FRAME_DONE", 64'(FRAME_DONE), 64'd0);
        checkEn    = 1'b1;
        RESET_N_IN = 1'b1;
        repeat (5) @(negedge MCLK_IN);

        // SCLK activity with SS deasserted must not disturb anything.
        for (int k = 0; k < 3; k++) begin
            sclkHalf(1'b1, 1'b1, 1'b0, 4'h0);
            sclkHalf(1'b0, 1'b0, 1'b0, 4'h0);
        end

        applyStimulus(56, 16'h0000, -1, got);
        checkOutput("NOP frame literal", 64'(got), 64'h0000_05BE_EF12_3456);

        applyStimulus(56, 16'h0000, 3, got);
        checkOutput("snapshot addr", 64'(got[23:0]), 64'h123456);
        checkOutput("snapshot seq", 64'(got[55:48]), 64'h01);
        ADDR_IN = 24'h123456;

        applyStimulus(16, 16'h0301, -1, got);
        checkOutput("WRITE literal", 64'(INPUT_SIGNAL), 64'h3);
        applyStimulus(16, 16'h0C02, -1, got);
        checkOutput("SET literal", 64'(INPUT_SIGNAL), 64'hF);
        applyStimulus(24, 16'h0503, -1, got);
        checkOutput("CLEAR literal", 64'(INPUT_SIGNAL), 64'hA);

        applyStimulus(12, 16'h0F01, -1, got);
        checkOutput("aborted payload literal", 64'(INPUT_SIGNAL), 64'hA);
        applyStimulus(5, 16'h0001, -1, got);

        DATA_IN          = 16'h1234;
        OUTPUT_SIGNAL_IN = 4'hC;
        for (int k = 0; k < 250; k++) begin
            applyStimulus(8, 16'h0000, -1, got);
        end
        applyStimulus(56, 16'h0000, -1, got);
        checkOutput("seq wrap literal", 64'(got[55:48]), 64'h00);
        checkOutput("seq wrap word", 64'(got), 64'h0000_0C12_3412_3456);

        // Abort a WRITE frame by reset at bit 20, after its payload has already landed.
        SPISI_IN = 1'b1;
        driveSs(1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            sclkHalf(1'b1, (i < 16) ? (16'h0501 >> i) & 16'h1 : 1'b0, i == 15, 4'h5);
            sclkHalf(1'b0, 1'b0, 1'b0, 4'h0);
        end
        checkOutput("pre-reset INPUT_SIGNAL", 64'(INPUT_SIGNAL), 64'h5);
        #2;
        RESET_N_IN = 1'b0;
        modelOe    = 1'b0;
        modelDone  = 1'b0;
        modelIsig  = 4'hA;
        modelSeq   = 8'h00;
        #1;
        checkOutput("reset abort SPISO_OE", 64'(SPISO_OE), 64'd0);
        checkOutput("reset abort INPUT_SIGNAL", 64'(INPUT_SIGNAL), 64'hA);
        repeat (3) @(negedge MCLK_IN);
        RESET_N_IN = 1'b1;
        repeat (10) @(negedge MCLK_IN);
        driveSs(1'b1, 0);
        applyStimulus(56, 16'h0000, -1, got);
        checkOutput("post-reset seq literal", 64'(got[55:48]), 64'h00);

        repeat (5) @(negedge MCLK_IN);
        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bus_monitor.md
Name: spi_bus_monitor

Overview:
Parametrised SPI-slave bus monitor clocked entirely from the system clock. SPI pins are synchronised and edge-detected, with no SPI-clock domain. At frame start the block takes an atomic snapshot of the CPU address, data and output-signal buses and shifts it out LSB first, followed by a frame sequence byte. In the same frame it accepts a command byte and a payload byte that write, set or clear the INPUT_SIGNAL bits driven into the design.

Parameters:
ADDR_WIDTH, 24, width of ADDR_IN
DATA_WIDTH, 16, width of DATA_IN
OSIG_WIDTH, 4, width of OUTPUT_SIGNAL_IN
ISIG_WIDTH, 4, width of INPUT_SIGNAL (1..8)
ISIG_INIT, 0, reset value of INPUT_SIGNAL

Ports:
MCLK_IN  in  1  system clock; must be at least 8x the SPICLK_IN frequency
RESET_N_IN  in  1  asynchronous active-low reset
SPICLK_IN  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous
SPISI_IN  in  1  master-to-slave data
SPISS_IN  in  1  slave select, active low
ADDR_IN  in  ADDR_WIDTH  monitored address bus
DATA_IN  in  DATA_WIDTH  monitored data bus
OUTPUT_SIGNAL_IN  in  OSIG_WIDTH  monitored control signals
INPUT_SIGNAL  out  ISIG_WIDTH  registered control bits written over SPI
SPISO  out  1  slave-to-master data
SPISO_OE  out  1  high while a frame is active; drives the external tristate buffer
FRAME_DONE  out  1  one-cycle pulse when a frame closes after a complete command byte

Behaviour:
- Reset values (async, RESET_N_IN low): INPUT_SIGNAL=ISIG_INIT, SPISO=0, SPISO_OE=0, FRAME_DONE=0, SEQ=0, state IDLE, bit counter=0.
- Synchronisation: SPICLK_IN, SPISI_IN and SPISS_IN each pass through 2 flops. Edge detect on the synchronised signals.
- Synchronisation latency: pin to detected edge is 3 MCLK cycles.
- Geometry: SNAP_W = ADDR_WIDTH+DATA_WIDTH+OSIG_WIDTH, rounded up to a multiple of 8. RESP_W = SNAP_W+8. Defaults give 48 and 56.
- Response word, LSB first: {SEQ[7:0], zero pad, OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN}. ADDR bit 0 is sent first.
- States: IDLE, CMD, PAYLOAD, DRAIN.
- IDLE -> CMD on a detected SS fall:
  - same cycle: load the shift register with the snapshot, drive SPISO = bit 0, set SPISO_OE=1, clear the bit counter and RX register.
  - the snapshot is taken only here; bus changes later in the frame are not visible.
- SCLK rise: sample SPISI into RX, LSB first (RX <= {SI, RX[7:1]}). Bit counter increments, saturating at RESP_W.
- SCLK fall: shift TX right, so SPISO = next bit. Once RESP_W bits have been shifted, SPISO=0 and further SCLK edges are ignored for TX.
- CMD, at the 8th rise, latch the command as {SI, RX[7:1]}:
  - opcode 0x00 NOP -> DRAIN.
  - opcodes 0x01 WRITE, 0x02 SET, 0x03 CLEAR -> PAYLOAD.
  - any other value is treated as NOP.
- PAYLOAD, at the 16th rise, take payload P = {SI, RX[7:1]}[ISIG_WIDTH-1:0] and update INPUT_SIGNAL on the next MCLK:
  - WRITE: INPUT_SIGNAL <= P
  - SET: INPUT_SIGNAL <= INPUT_SIGNAL | P
  - CLEAR: INPUT_SIGNAL <= INPUT_SIGNAL & ~P
  - then -> DRAIN.
- Detected SS rise, from any non-IDLE state -> IDLE:
  - SPISO_OE=0 and SPISO=0 in the same cycle.
  - if at least 8 bits were received, pulse FRAME_DONE for one cycle and increment SEQ, wrapping 0xFF -> 0x00.
  - a frame ending mid-payload (8..15 bits) discards the payload: INPUT_SIGNAL unchanged, SEQ still increments.
  - a frame with fewer than 8 bits produces no pulse and no increment.
- Simultaneous detected SS rise and SCLK edge in one cycle: SS rise wins and the SCLK edge is dropped.
- SCLK edges while SS is high are ignored.
- Async reset mid-frame aborts the frame immediately. SS must go high and then fall again before a new frame starts.

Decomposition:
- Package spi_monitor_pkg:
  - opcode constants OP_NOP=8'h00, OP_WRITE=8'h01, OP_SET=8'h02, OP_CLEAR=8'h03
  - state enum
  - function resp_width(a,d,o) returning RESP_W
- Sub-module spi_sync_edge, instantiated 3 times: 2-flop synchroniser with async active-low reset, outputting level, rise and fall.

Test Plan:
- Reset: hold RESET_N_IN low with ISIG_INIT=4'hA -> INPUT_SIGNAL=4'hA, SPISO_OE=0, FRAME_DONE=0.
- Read-only NOP frame: ADDR=24'h123456, DATA=16'hBEEF, OSIG=4'h5, 56 SCLKs at MCLK/10 -> MISO carries 56'h00_05BEEF123456 LSB first, FRAME_DONE pulses once, SEQ becomes 1.
- Snapshot atomicity: change ADDR to 24'hFFFFFF after the 3rd SCLK -> the received address is still 24'h123456.
- Write then modify: WRITE 0x03 -> INPUT_SIGNAL=4'h3; then SET 0x0C -> 4'hF; then CLEAR 0x05 -> 4'hA; each update lands the MCLK after the 16th rise.
- Aborted payload: WRITE opcode followed by SS high after 12 bits -> INPUT_SIGNAL unchanged, FRAME_DONE pulses. A 5-bit frame -> no pulse, SEQ unchanged.
- SEQ wrap and reset: 256 complete frames -> SEQ byte reads 0x00. Assert reset mid-frame at bit 20 -> SPISO_OE=0 immediately, SEQ=0.
